mem_stage: RTL and testbench

- Pipeline memory-access stage directly upstream of the write-back stage.
- Accepts one instruction from EX over a valid/ready handshake and issues at most one request on the data-memory request/response bus.
- Aligns, sign- or zero-extends load data, builds store strobes and replicated write data, and flags misaligned accesses (ALE).
- Presents the result, destination register and exception flag to WB over a valid/ready handshake.

---
 rtl/mem_stage.sv | 201 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage between EX and WB.
// Ports: clk, reset (async, active-low); EX handshake left_valid/left_ready with
//   ex_* instruction fields; data_* memory request/response bus; WB handshake
//   right_valid/right_ready with ms_* result fields.
module mem_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        left_valid,
    output logic        left_ready,
    input  logic [31:0] ex_pc,
    input  logic [4:0]  ex_wreg_index,
    input  logic        ex_wreg_en,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_mem_en,
    input  logic [3:0]  ex_mem_op,
    input  logic        ex_excp,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        right_valid,
    input  logic        right_ready,
    output logic [31:0] ms_pc,
    output logic [31:0] ms_result,
    output logic [4:0]  ms_wreg_index,
    output logic        ms_wreg_en,
    output logic        ms_excp,
    output logic        ms_ale,
    output logic [31:0] ms_badv
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0] r_pc;
    logic [4:0]  r_wreg_index;
    logic        r_wreg_en;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic [3:0]  r_mem_op;
    logic        r_excp;
    logic        r_ale;
    logic [31:0] r_badv;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_ale;
    logic        w_to_req;
    logic [1:0]  w_off;
    logic        w_sz_b;
    logic        w_sz_h;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;

    assign w_accept = left_valid & left_ready;
    assign w_ale = ex_mem_en &
        ((ex_mem_op[3:2] == 2'b01 & ex_alu_result[0]) |
         (ex_mem_op[3:2] == 2'b10 & (|ex_alu_result[1:0])));
    assign w_to_req = ex_mem_en & ~ex_excp & ~w_ale;

    assign w_off  = r_addr[1:0];
    assign w_sz_b = (r_mem_op[3:2] == 2'b00);
    assign w_sz_h = (r_mem_op[3:2] == 2'b01);

    // Load extraction, store strobes and lane replication
    always_comb begin
        w_byte = data_rdata[7:0];
        unique case (w_off)
            2'd0: w_byte = data_rdata[7:0];
            2'd1: w_byte = data_rdata[15:8];
            2'd2: w_byte = data_rdata[23:16];
            2'd3: w_byte = data_rdata[31:24];
            default: w_byte = data_rdata[7:0];
        endcase
        w_half  = w_off[1] ? data_rdata[31:16] : data_rdata[15:0];
        w_load  = data_rdata;
        w_strb  = 4'b1111;
        w_wdata = r_sdata;
        unique case (1'b1)
            w_sz_b: begin
                w_load  = {{24{w_byte[7] & ~r_mem_op[0]}}, w_byte};
                w_strb  = 4'b0001 << w_off;
                w_wdata = {4{r_sdata[7:0]}};
            end
            w_sz_h: begin
                w_load  = {{16{w_half[15] & ~r_mem_op[0]}}, w_half};
                w_strb  = 4'b0011 << w_off;
                w_wdata = {2{r_sdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = w_to_req ? S_REQ : S_HOLD;
            end
            S_REQ: begin
                if (flush)             w_next = data_addr_ok ? S_DRAIN : S_IDLE;
                else if (data_addr_ok) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (flush)             w_next = data_data_ok ? S_IDLE : S_DRAIN;
                else if (data_data_ok) w_next = S_HOLD;
            end
            S_HOLD: begin
                if (flush)            w_next = S_IDLE;
                else if (w_accept)    w_next = w_to_req ? S_REQ : S_HOLD;
                else if (right_ready) w_next = S_IDLE;
            end
            S_DRAIN: begin
                // The orphaned response must be swallowed before reuse
                if (data_data_ok) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        left_ready  = 1'b0;
        data_req    = 1'b0;
        right_valid = 1'b0;
        data_wstrb  = 4'b0000;
        unique case (r_state)
            S_IDLE:  left_ready = reset & ~flush;
            S_REQ: begin
                data_req   = 1'b1;
                data_wstrb = r_mem_op[1] ? w_strb : 4'b0000;
            end
            S_HOLD: begin
                right_valid = 1'b1;
                left_ready  = reset & ~flush & right_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_PC;
            r_wreg_index <= 5'd0;
            r_wreg_en    <= 1'b0;
            r_addr       <= 32'd0;
            r_sdata      <= 32'd0;
            r_mem_op     <= 4'd0;
            r_excp       <= 1'b0;
            r_ale        <= 1'b0;
            r_badv       <= 32'd0;
            r_result     <= 32'd0;
        end else if (w_accept) begin
            r_pc         <= ex_pc;
            r_wreg_index <= ex_wreg_index;
            r_wreg_en    <= ex_wreg_en;
            r_addr       <= ex_alu_result;
            r_sdata      <= ex_store_data;
            r_mem_op     <= ex_mem_op;
            r_excp       <= ex_excp | w_ale;
            r_ale        <= w_ale;
            r_badv       <= w_ale ? ex_alu_result : 32'd0;
            r_result     <= ex_alu_result;
        end else if (r_state == S_WAIT && data_data_ok && !flush) begin
            r_result <= r_mem_op[1] ? 32'd0 : w_load;
        end
    end

    assign data_wr       = r_mem_op[1];
    assign data_size     = r_mem_op[3:2];
    assign data_addr     = r_addr;
    assign data_wdata    = w_wdata;
    assign ms_pc         = r_pc;
    assign ms_result     = r_result;
    assign ms_wreg_index = r_wreg_index;
    assign ms_wreg_en    = r_wreg_en;
    assign ms_excp       = r_excp;
    assign ms_ale        = r_ale;
    assign ms_badv       = r_badv;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven bench for mem_stage with a result scoreboard
// and hand-written flush / stall / reset sequences.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        left_valid;
    logic        left_ready;
    logic [31:0] ex_pc;
    logic [4:0]  ex_wreg_index;
    logic        ex_wreg_en;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_en;
    logic [3:0]  ex_mem_op;
    logic        ex_excp;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        right_valid;
    logic        right_ready;
    logic [31:0] ms_pc;
    logic [31:0] ms_result;
    logic [4:0]  ms_wreg_index;
    logic        ms_wreg_en;
    logic        ms_excp;
    logic        ms_ale;
    logic [31:0] ms_badv;

    mem_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .left_valid(left_valid), .left_ready(left_ready),
        .ex_pc(ex_pc), .ex_wreg_index(ex_wreg_index),
        .ex_wreg_en(ex_wreg_en), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_mem_en(ex_mem_en),
        .ex_mem_op(ex_mem_op), .ex_excp(ex_excp),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .right_valid(right_valid), .right_ready(right_ready),
        .ms_pc(ms_pc), .ms_result(ms_result),
        .ms_wreg_index(ms_wreg_index), .ms_wreg_en(ms_wreg_en),
        .ms_excp(ms_excp), .ms_ale(ms_ale), .ms_badv(ms_badv)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  idx;
        logic        wen;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic        men;
        logic [3:0]  op;
        logic        excp;
        logic [31:0] rdata;
        logic        ereq;
        logic [3:0]  estrb;
        logic [31:0] ewdata;
        logic [31:0] eres;
        logic        eale;
        logic        eexcp;
        logic [31:0] ebadv;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  idx;
        logic        wen;
        logic [31:0] res;
        logic        ale;
        logic        excp;
        logic [31:0] badv;
    } exp_t;

    exp_t q[$];
    vec_t vt[15];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic        mem_auto;
    logic        a_aok, a_dok, m_aok, m_dok;
    logic [31:0] a_rdata, m_rdata, cur_rdata;
    int          mem_lat;
    int          pend;
    int          req_cnt;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_strb;
    logic        cap_wr;

    assign data_addr_ok = mem_auto ? a_aok : m_aok;
    assign data_data_ok = mem_auto ? a_dok : m_dok;
    assign data_rdata   = mem_auto ? a_rdata : m_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Memory model: addr_ok on the first request cycle, data_ok mem_lat later
    initial begin
        a_aok = 0; a_dok = 0; a_rdata = 0; pend = 0; req_cnt = 0;
        cap_addr = 0; cap_wdata = 0; cap_strb = 0; cap_wr = 0;
        forever begin
            @(negedge clk);
            a_aok = 0;
            a_dok = 0;
            if (mem_auto) begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        a_dok = 1;
                        a_rdata = cur_rdata;
                    end
                end else if (data_req) begin
                    a_aok = 1;
                    pend = mem_lat;
                    req_cnt++;
                    cap_addr = data_addr;
                    cap_wdata = data_wdata;
                    cap_strb = data_wstrb;
                    cap_wr = data_wr;
                end
            end
        end
    end

    // Scoreboard consumer: each WB handshake pops one expected result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (right_valid && right_ready && !flush) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got pc %h want none",
                             ms_pc);
                end else begin
                    e = q.pop_front();
                    chk("wb_pc", ms_pc, e.pc);
                    chk("wb_result", ms_result, e.res);
                    chk("wb_idx", {27'd0, ms_wreg_index}, {27'd0, e.idx});
                    chk("wb_wen", {31'd0, ms_wreg_en}, {31'd0, e.wen});
                    chk("wb_excp", {31'd0, ms_excp}, {31'd0, e.excp});
                    chk("wb_ale", {31'd0, ms_ale}, {31'd0, e.ale});
                    chk("wb_badv", ms_badv, e.badv);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic vec_t mk(
        input logic [31:0] pc, input logic [4:0] idx, input logic wen,
        input logic [31:0] alu, input logic [31:0] sdata, input logic men,
        input logic [3:0] op, input logic excp, input logic [31:0] rdata,
        input logic ereq, input logic [3:0] estrb,
        input logic [31:0] ewdata, input logic [31:0] eres,
        input logic eale, input logic eexcp, input logic [31:0] ebadv);
        vec_t v;
        v.pc = pc; v.idx = idx; v.wen = wen; v.alu = alu;
        v.sdata = sdata; v.men = men; v.op = op; v.excp = excp;
        v.rdata = rdata; v.ereq = ereq; v.estrb = estrb;
        v.ewdata = ewdata; v.eres = eres; v.eale = eale;
        v.eexcp = eexcp; v.ebadv = ebadv;
        return v;
    endfunction

    function automatic exp_t to_exp(input vec_t v);
        exp_t e;
        e.pc = v.pc; e.idx = v.idx; e.wen = v.wen; e.res = v.eres;
        e.ale = v.eale; e.excp = v.eexcp; e.badv = v.ebadv;
        return e;
    endfunction

    task automatic send(input vec_t v, input bit push);
        bit got;
        @(posedge clk); #1;
        ex_pc = v.pc; ex_wreg_index = v.idx; ex_wreg_en = v.wen;
        ex_alu_result = v.alu; ex_store_data = v.sdata;
        ex_mem_en = v.men; ex_mem_op = v.op; ex_excp = v.excp;
        cur_rdata = v.rdata;
        left_valid = 1;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (left_ready) got = 1;
        end
        if (!got) timeout("accept");
        else if (push) q.push_back(to_exp(v));
        @(posedge clk); #1;
        left_valid = 0;
    endtask

    task automatic wait_done(input string nm);
        for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            timeout(nm);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int r0;
        r0 = req_cnt;
        send(v, 1'b1);
        wait_done(nm);
        chk({nm, "_reqs"}, req_cnt - r0, {31'd0, v.ereq});
        if (v.ereq) begin
            chk({nm, "_addr"}, cap_addr, v.alu);
            chk({nm, "_wr"}, {31'd0, cap_wr}, {31'd0, v.op[1]});
            chk({nm, "_strb"}, {28'd0, cap_strb}, {28'd0, v.estrb});
            if (v.op[1]) chk({nm, "_wdata"}, cap_wdata, v.ewdata);
        end
    endtask

    initial begin
        exp_t ea;
        vec_t vb;
        reset = 0; flush = 0; left_valid = 0; right_ready = 1;
        ex_pc = 0; ex_wreg_index = 0; ex_wreg_en = 0; ex_alu_result = 0;
        ex_store_data = 0; ex_mem_en = 0; ex_mem_op = 0; ex_excp = 0;
        mem_auto = 1; m_aok = 0; m_dok = 0; m_rdata = 0;
        cur_rdata = 0; mem_lat = 1;

        //        pc           idx  wen alu          sdata        men op      ex rdata        rq strb     wdata        result       ale exc badv
        vt[0]  = mk(32'h100, 5'd1, 1, 32'h1003, 32'h0,        1, 4'b0000, 0, 32'h80000000, 1, 4'b0000, 32'h0,        32'hFFFFFF80, 0, 0, 32'h0);
        vt[1]  = mk(32'h104, 5'd2, 1, 32'h1003, 32'h0,        1, 4'b0001, 0, 32'h80000000, 1, 4'b0000, 32'h0,        32'h00000080, 0, 0, 32'h0);
        vt[2]  = mk(32'h108, 5'd0, 0, 32'h1002, 32'h1234ABCD, 1, 4'b0110, 0, 32'h0,        1, 4'b1100, 32'hABCDABCD, 32'h0,        0, 0, 32'h0);
        vt[3]  = mk(32'h10c, 5'd3, 1, 32'h1002, 32'h0,        1, 4'b1000, 0, 32'h0,        0, 4'b0000, 32'h0,        32'h1002,     1, 1, 32'h1002);
        vt[4]  = mk(32'h110, 5'd4, 1, 32'hCAFEBABE, 32'h0,    0, 4'b0000, 0, 32'h0,        0, 4'b0000, 32'h0,        32'hCAFEBABE, 0, 0, 32'h0);
        vt[5]  = mk(32'h114, 5'd5, 1, 32'h2002, 32'h0,        1, 4'b0100, 0, 32'h80011234, 1, 4'b0000, 32'h0,        32'hFFFF8001, 0, 0, 32'h0);
        vt[6]  = mk(32'h118, 5'd6, 1, 32'h2000, 32'h0,        1, 4'b0101, 0, 32'h8001F234, 1, 4'b0000, 32'h0,        32'h0000F234, 0, 0, 32'h0);
        vt[7]  = mk(32'h11c, 5'd0, 0, 32'h3001, 32'h000000A5, 1, 4'b0010, 0, 32'h0,        1, 4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0, 32'h0);
        vt[8]  = mk(32'h120, 5'd0, 0, 32'h3004, 32'h11223344, 1, 4'b1010, 0, 32'h0,        1, 4'b1111, 32'h11223344, 32'h0,        0, 0, 32'h0);
        vt[9]  = mk(32'h124, 5'd9, 1, 32'h4000, 32'h0,        1, 4'b1000, 0, 32'h55667788, 1, 4'b0000, 32'h0,        32'h55667788, 0, 0, 32'h0);
        vt[10] = mk(32'h128, 5'd10, 1, 32'h5000, 32'h0,       1, 4'b1000, 1, 32'h0,        0, 4'b0000, 32'h0,        32'h5000,     0, 1, 32'h0);
        vt[11] = mk(32'h12c, 5'd11, 1, 32'h6001, 32'h0,       1, 4'b0100, 0, 32'h0,        0, 4'b0000, 32'h0,        32'h6001,     1, 1, 32'h6001);
        vt[12] = mk(32'h130, 5'd0, 0, 32'h6003, 32'h5555,     1, 4'b0110, 0, 32'h0,        0, 4'b0000, 32'h0,        32'h6003,     1, 1, 32'h6003);
        vt[13] = mk(32'h134, 5'd13, 1, 32'h7001, 32'h0,       1, 4'b0000, 0, 32'h00007F00, 1, 4'b0000, 32'h0,        32'h0000007F, 0, 0, 32'h0);
        vt[14] = mk(32'h138, 5'd14, 1, 32'h7002, 32'h00C3,    1, 4'b0010, 0, 32'h0,        1, 4'b0100, 32'hC3C3C3C3, 32'h0,        0, 0, 32'h0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_left_ready", {31'd0, left_ready}, 32'd0);
        chk("rst_right_valid", {31'd0, right_valid}, 32'd0);
        chk("rst_data_req", {31'd0, data_req}, 32'd0);
        chk("rst_ms_pc", ms_pc, 32'h1c000000);
        chk("rst_ms_result", ms_result, 32'd0);
        chk("rst_wstrb", {28'd0, data_wstrb}, 32'd0);
        reset = 1;

        for (int i = 0; i < 15; i++) begin
            mem_lat = (i % 3) + 1;
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        // Flush in WAIT: response arrives later and must be drained
        mem_auto = 0;
        send(vt[9], 1'b0);
        m_aok = 1;
        @(posedge clk); #1;
        m_aok = 0;
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("drain_left_ready", {31'd0, left_ready}, 32'd0);
            chk("drain_right_valid", {31'd0, right_valid}, 32'd0);
            @(posedge clk); #1;
        end
        m_dok = 1;
        m_rdata = 32'h0000DEAD;
        @(negedge clk);
        chk("drain_last_left_ready", {31'd0, left_ready}, 32'd0);
        @(posedge clk); #1;
        m_dok = 0;
        @(negedge clk);
        chk("post_drain_left_ready", {31'd0, left_ready}, 32'd1);
        chk("post_drain_right_valid", {31'd0, right_valid}, 32'd0);
        mem_auto = 1;
        mem_lat = 2;
        run_vec(vt[0], "after_flush");

        // HOLD stall with back-to-back release
        right_ready = 0;
        send(vt[4], 1'b1);
        ea = to_exp(vt[4]);
        vb = mk(32'h200, 5'd7, 1, 32'h0BADF00D, 32'h0, 0, 4'b0000, 0,
                32'h0, 0, 4'b0000, 32'h0, 32'h0BADF00D, 0, 0, 32'h0);
        ex_pc = vb.pc; ex_wreg_index = vb.idx; ex_wreg_en = vb.wen;
        ex_alu_result = vb.alu; ex_mem_en = 0; ex_mem_op = 0; ex_excp = 0;
        left_valid = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_right_valid", {31'd0, right_valid}, 32'd1);
            chk("stall_left_ready", {31'd0, left_ready}, 32'd0);
            chk("stall_result", ms_result, ea.res);
            chk("stall_pc", ms_pc, ea.pc);
        end
        @(posedge clk); #1;
        right_ready = 1;
        @(negedge clk);
        chk("release_left_ready", {31'd0, left_ready}, 32'd1);
        q.push_back(to_exp(vb));
        @(posedge clk); #1;
        left_valid = 0;
        @(negedge clk);
        chk("b2b_right_valid", {31'd0, right_valid}, 32'd1);
        chk("b2b_result", ms_result, vb.eres);
        wait_done("b2b");

        // Reset asserted while waiting for load data
        mem_auto = 0;
        send(vt[9], 1'b0);
        m_aok = 1;
        @(posedge clk); #1;
        m_aok = 0;
        #2;
        reset = 0;
        #1;
        chk("mid_rst_data_req", {31'd0, data_req}, 32'd0);
        chk("mid_rst_right_valid", {31'd0, right_valid}, 32'd0);
        chk("mid_rst_left_ready", {31'd0, left_ready}, 32'd0);
        chk("mid_rst_ms_pc", ms_pc, 32'h1c000000);
        chk("mid_rst_ms_result", ms_result, 32'd0);
        chk("mid_rst_data_addr", data_addr, 32'd0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("post_rst_left_ready", {31'd0, left_ready}, 32'd1);
        chk("post_rst_right_valid", {31'd0, right_valid}, 32'd0);
        mem_auto = 1;
        mem_lat = 1;
        run_vec(vt[2], "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
